// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: redirect, hold and squash for the IF stage.
// Optional interrupt redirect enabled with `define FETCH_CTRL_IRQ_EN.
module fetch_ctrl #(
  parameter int           N          = 32,
  parameter int           BUBBLES    = 2,
  parameter logic [N-1:0] IRQ_VECTOR = 32'h0000_0010
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc,
  input  logic         stall_req,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         jmp_req,
  input  logic [N-1:0] jmp_target,
  input  logic         irq,
  output logic [N-1:0] jmp_pc,
  output logic         pc_selector,
  output logic         flush,
  output logic         stalled,
  output logic         irq_ack,
  output logic [N-1:0] epc
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] SQUASH   = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  logic [1:0]   state, n_state;
  logic [2:0]   cnt, n_cnt;
  logic [N-1:0] n_jmp_pc, n_epc;
  logic         n_sel, n_flush, n_stalled, n_ack;
  logic         irq_hit, redir, take;
  logic [N-1:0] target;

`ifdef FETCH_CTRL_IRQ_EN
  assign irq_hit = irq;
`else
  logic unused;
  assign unused  = irq;
  assign irq_hit = 1'b0;
`endif

  assign redir  = irq_hit | br_taken | jmp_req;
  assign target = irq_hit  ? IRQ_VECTOR :
                  br_taken ? br_target  : jmp_target;
  // Only RUN and HOLD listen to requests; others come from squashed slots
  assign take   = redir & ((state == RUN) | (state == HOLD));

  always_comb begin
    n_state   = state;
    n_cnt     = cnt;
    n_jmp_pc  = jmp_pc;
    n_sel     = pc_selector;
    n_flush   = flush;
    n_stalled = stalled;
    n_ack     = 1'b0;
    n_epc     = epc;
    if (take) begin
      n_state   = REDIRECT;
      n_jmp_pc  = target;
      n_sel     = 1'b1;
      n_flush   = 1'b1;
      n_stalled = 1'b0;
      n_ack     = irq_hit;
      if (irq_hit) n_epc = pc;
    end else begin
      case (state)
        RUN: begin
          if (stall_req) begin
            n_state   = HOLD;
            n_jmp_pc  = pc;
            n_sel     = 1'b1;
            n_stalled = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_req) begin
            n_state   = RUN;
            n_sel     = 1'b0;
            n_stalled = 1'b0;
          end
        end
        REDIRECT: begin
          n_sel = 1'b0;
          if (BUBBLES == 1) begin
            n_state = RUN;
            n_flush = 1'b0;
          end else begin
            n_state = SQUASH;
            n_cnt   = 3'(BUBBLES - 2);
            n_flush = 1'b1;
          end
        end
        SQUASH: begin
          if (cnt == 3'd0) begin
            n_state = RUN;
            n_flush = 1'b0;
          end else begin
            n_cnt = cnt - 3'd1;
          end
        end
        default: begin
          n_state   = RUN;
          n_cnt     = 3'd0;
          n_sel     = 1'b0;
          n_flush   = 1'b0;
          n_stalled = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 3'd0;
      jmp_pc      <= '0;
      pc_selector <= 1'b0;
      flush       <= 1'b0;
      stalled     <= 1'b0;
      irq_ack     <= 1'b0;
      epc         <= '0;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      jmp_pc      <= n_jmp_pc;
      pc_selector <= n_sel;
      flush       <= n_flush;
      stalled     <= n_stalled;
      irq_ack     <= n_ack;
      epc         <= n_epc;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table through a scoreboard queue,
// plus hand-written reset sequences.
module tb_fetch_ctrl;
  localparam int N = 32;
`ifdef FETCH_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pc, br_target, jmp_target;
  logic         stall_req, br_taken, jmp_req, irq;
  logic [N-1:0] jmp_pc, epc;
  logic         pc_selector, flush, stalled, irq_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.N(N), .BUBBLES(2), .IRQ_VECTOR(32'h10)) dut (
    .clk(clk), .reset(reset), .pc(pc), .stall_req(stall_req),
    .br_taken(br_taken), .br_target(br_target), .jmp_req(jmp_req),
    .jmp_target(jmp_target), .irq(irq), .jmp_pc(jmp_pc),
    .pc_selector(pc_selector), .flush(flush), .stalled(stalled),
    .irq_ack(irq_ack), .epc(epc)
  );

  typedef struct {
    logic [N-1:0] jp;
    logic         sel, fl, st, ack;
    logic [N-1:0] ep;
  } out_t;

  typedef struct {
    logic [N-1:0] pc;
    logic         stall, br;
    logic [N-1:0] brt;
    logic         jmp;
    logic [N-1:0] jt;
    logic         irq;
    out_t         exp;
  } vec_t;

  vec_t v[$];
  out_t sb[$];

  function automatic vec_t mk(logic [N-1:0] p, logic s, logic b,
      logic [N-1:0] bt, logic j, logic [N-1:0] t, logic i,
      logic [N-1:0] jp, logic sel, logic fl, logic st,
      logic ack, logic [N-1:0] ep);
    vec_t r;
    r.pc = p; r.stall = s; r.br = b; r.brt = bt;
    r.jmp = j; r.jt = t; r.irq = i;
    r.exp.jp = jp; r.exp.sel = sel; r.exp.fl = fl;
    r.exp.st = st; r.exp.ack = ack; r.exp.ep = ep;
    return r;
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(string tag, out_t e);
    check({tag, ".jmp_pc"}, jmp_pc, e.jp);
    check({tag, ".pc_selector"}, N'(pc_selector), N'(e.sel));
    check({tag, ".flush"}, N'(flush), N'(e.fl));
    check({tag, ".stalled"}, N'(stalled), N'(e.st));
    check({tag, ".irq_ack"}, N'(irq_ack), N'(e.ack));
    check({tag, ".epc"}, epc, e.ep);
  endtask

  task automatic drive_idle(logic [N-1:0] p);
    pc = p; stall_req = 0; br_taken = 0; br_target = 0;
    jmp_req = 0; jmp_target = 0; irq = 0;
  endtask

  initial begin
    logic [N-1:0] ij, ie;
    out_t e, z;
    z.jp = '0; z.sel = 0; z.fl = 0; z.st = 0; z.ack = 0; z.ep = '0;
    ij = IRQ_ON ? 32'h10 : 32'h600;
    ie = IRQ_ON ? 32'hC0 : 32'h0;

    // pc, stall, br, brt, jmp, jt, irq | jp, sel, fl, st, ack, epc
    v.push_back(mk('h40, 0, 0, 0,     0, 0,     0, 0,     0, 0, 0, 0, 0));
    v.push_back(mk('h40, 0, 1, 'h100, 0, 0,     0, 'h100, 1, 1, 0, 0, 0));
    v.push_back(mk('h44, 0, 0, 0,     0, 0,     0, 'h100, 0, 1, 0, 0, 0));
    v.push_back(mk('h100,0, 0, 0,     0, 0,     0, 'h100, 0, 0, 0, 0, 0));
    v.push_back(mk('h104,0, 1, 'h200, 1, 'h300, 0, 'h200, 1, 1, 0, 0, 0));
    v.push_back(mk('h108,0, 0, 0,     1, 'h300, 0, 'h200, 0, 1, 0, 0, 0));
    v.push_back(mk('h200,0, 0, 0,     0, 0,     0, 'h200, 0, 0, 0, 0, 0));
    v.push_back(mk('h80, 1, 0, 0,     0, 0,     0, 'h80,  1, 0, 1, 0, 0));
    v.push_back(mk('h80, 1, 0, 0,     0, 0,     0, 'h80,  1, 0, 1, 0, 0));
    v.push_back(mk('h80, 1, 0, 0,     0, 0,     0, 'h80,  1, 0, 1, 0, 0));
    v.push_back(mk('h80, 0, 0, 0,     0, 0,     0, 'h80,  0, 0, 0, 0, 0));
    v.push_back(mk('h90, 1, 0, 0,     0, 0,     0, 'h90,  1, 0, 1, 0, 0));
    v.push_back(mk('h90, 1, 1, 'h500, 0, 0,     0, 'h500, 1, 1, 0, 0, 0));
    v.push_back(mk('h90, 1, 0, 0,     0, 0,     0, 'h500, 0, 1, 0, 0, 0));
    v.push_back(mk('h94, 1, 0, 0,     0, 0,     0, 'h500, 0, 0, 0, 0, 0));
    v.push_back(mk('h500,0, 0, 0,     0, 0,     0, 'h500, 0, 0, 0, 0, 0));
    v.push_back(mk('hC0, 0, 1, 'h600, 0, 0,     1, ij,    1, 1, 0, IRQ_ON, ie));
    v.push_back(mk('hC4, 0, 0, 0,     0, 0,     0, ij,    0, 1, 0, 0, ie));
    v.push_back(mk('hC8, 0, 0, 0,     0, 0,     0, ij,    0, 0, 0, 0, ie));
    v.push_back(mk('hCC, 0, 0, 0,     1, 'h700, 0, 'h700, 1, 1, 0, 0, ie));
    v.push_back(mk('hD0, 0, 0, 0,     0, 0,     0, 'h700, 0, 1, 0, 0, ie));
    v.push_back(mk('h700,0, 0, 0,     0, 0,     0, 'h700, 0, 0, 0, 0, ie));
    v.push_back(mk('h704,1, 0, 0,     1, 'h800, 0, 'h800, 1, 1, 0, 0, ie));
    v.push_back(mk('h708,1, 0, 0,     0, 0,     0, 'h800, 0, 1, 0, 0, ie));
    v.push_back(mk('h70C,1, 0, 0,     0, 0,     0, 'h800, 0, 0, 0, 0, ie));
    v.push_back(mk('h44, 1, 0, 0,     0, 0,     0, 'h44,  1, 0, 1, 0, ie));
    v.push_back(mk('h44, 0, 0, 0,     0, 0,     0, 'h44,  0, 0, 0, 0, ie));

    reset = 1'b1;
    drive_idle('h40);
    #12;
    compare("reset", z);
    @(negedge clk);
    reset = 1'b0;

    foreach (v[i]) begin
      @(negedge clk);
      pc = v[i].pc; stall_req = v[i].stall; br_taken = v[i].br;
      br_target = v[i].brt; jmp_req = v[i].jmp;
      jmp_target = v[i].jt; irq = v[i].irq;
      sb.push_back(v[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare($sformatf("vec%0d", i), e);
    end

    // Asynchronous reset while in SQUASH
    @(negedge clk);
    drive_idle('h40);
    br_taken = 1; br_target = 'h100;
    @(negedge clk);
    drive_idle('h44);
    @(posedge clk);
    #1;
    check("pre_rst.flush", N'(flush), N'(1'b1));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sq.flush", N'(flush), N'(1'b0));
    check("rst_sq.pc_selector", N'(pc_selector), N'(1'b0));
    check("rst_sq.jmp_pc", jmp_pc, N'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare("post_rst", z);

    // Asynchronous reset while in HOLD
    @(negedge clk);
    stall_req = 1; pc = 'h80;
    @(posedge clk);
    #1;
    check("hold.stalled", N'(stalled), N'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    check("rst_hold.stalled", N'(stalled), N'(1'b0));
    check("rst_hold.jmp_pc", jmp_pc, N'(0));
    @(negedge clk);
    drive_idle('h40);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare("post_rst2", z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction fetch stage. Drives the stage's `jmp_pc`/`pc_selector` pair to perform three jobs:
- redirect fetch on taken branches, jumps and (optionally) interrupts;
- hold the fetch address during pipeline stalls;
- squash the wrong-path instructions already in flight.

It sits between the hazard/branch logic (EX stage, hazard unit) and the fetch stage, and arbitrates concurrent redirect sources by fixed priority.

## Interface
Parameters:
- `N`, 32, address width.
- `BUBBLES`, 2, younger pipeline slots squashed per redirect (legal 1..4).
- `IRQ_VECTOR`, 32'h0000_0010, interrupt handler address. Used only with `FETCH_CTRL_IRQ_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pc`  in  N  current fetch address from the fetch stage.
- `stall_req`  in  1  hazard unit requests that fetch hold.
- `br_taken`  in  1  EX stage branch resolved taken.
- `br_target`  in  N  branch target.
- `jmp_req`  in  1  unconditional jump request.
- `jmp_target`  in  N  jump target.
- `irq`  in  1  level interrupt request.
- `jmp_pc`  out  N  address forced onto the fetch mux; registered.
- `pc_selector`  out  1  1 selects `jmp_pc` as fetch address; registered.
- `flush`  out  1  squash IF/ID and younger pipeline registers; registered.
- `stalled`  out  1  controller is in HOLD; registered.
- `irq_ack`  out  1  one-cycle interrupt acceptance pulse; registered.
- `epc`  out  N  return address captured at interrupt acceptance.

## Operation
States are RUN, REDIRECT, SQUASH and HOLD. A 3-bit down-counter `cnt` runs in SQUASH.

Redirect priority: `irq` (macro on) > `br_taken` > `jmp_req`.

- **RUN**: `pc_selector`=0, `flush`=0.
  - On any redirect source: latch the winning target into `jmp_pc`, go to REDIRECT.
  - Otherwise, on `stall_req`: latch `pc` into `jmp_pc`, go to HOLD.
  - Redirect beats stall in the same cycle.
- **REDIRECT** (exactly 1 cycle): `pc_selector`=1, `flush`=1.
  - If `BUBBLES`=1, go to RUN.
  - Otherwise load `cnt`=`BUBBLES`-2 and go to SQUASH.
- **SQUASH**: `pc_selector`=0, `flush`=1. Decrement `cnt`; go to RUN after the cycle with `cnt`=0.
- **HOLD**: `pc_selector`=1, `jmp_pc` unchanged, `stalled`=1, so the same address is refetched every cycle.
  - Redirect source present: relatch `jmp_pc`, go to REDIRECT. The redirect wins over the stall.
  - Else `stall_req`=0: go to RUN. Fetch resumes from the fetch stage's internal register (held address + 4).
- **Wrong-path inputs**: `br_taken`, `jmp_req` and `stall_req` are ignored in REDIRECT and SQUASH because they come from squashed instructions.
- **Pending interrupt**: `irq` is level-sensitive. If it arrives during REDIRECT or SQUASH it is accepted on the first RUN cycle after.

## Timing
- All outputs are registered. A request sampled at edge t takes effect in the cycle after t, i.e. the target is fetched in cycle t+1.
- Redirect latency is 1 cycle. `flush` is high for exactly `BUBBLES` consecutive cycles: REDIRECT plus (`BUBBLES`-1) SQUASH cycles.
- Minimum spacing between accepted redirects is `BUBBLES`+1 cycles.
- Reset values: state RUN, `cnt`=0, `jmp_pc`=0, `pc_selector`=0, `flush`=0, `stalled`=0, `irq_ack`=0, `epc`=0.
- Reset asserted mid-REDIRECT, SQUASH or HOLD returns immediately, asynchronously, to the reset values; no redirect survives.
- `stall_req` held high indefinitely keeps HOLD with no limit; `jmp_pc` is stable throughout.

## Configuration
- `FETCH_CTRL_IRQ_EN` defined:
  - `irq` takes part in arbitration.
  - On acceptance: `jmp_pc`←`IRQ_VECTOR`, `epc`←`pc`, and `irq_ack` pulses for 1 cycle, aligned with REDIRECT.
- `FETCH_CTRL_IRQ_EN` undefined:
  - The `irq`, `irq_ack` and `epc` ports remain.
  - `irq` is ignored; `irq_ack` is constant 0; `epc` is constant 0.

## Test plan
- Reset with `pc`=32'h40, then `br_taken`=1, `br_target`=32'h100 for 1 cycle -> next cycle `pc_selector`=1, `jmp_pc`=32'h100; `flush` high 2 cycles (`BUBBLES`=2); then `pc_selector`=0.
- `br_taken` (target 32'h200) and `jmp_req` (target 32'h300) in the same cycle -> `jmp_pc`=32'h200. A `jmp_req` in the following SQUASH cycle is ignored.
- `stall_req` high 3 cycles while `pc`=32'h80 -> `pc_selector`=1, `jmp_pc`=32'h80, `stalled`=1 for 3 cycles; then `pc_selector`=0, `stalled`=0.
- During HOLD, `br_taken` with target 32'h500 -> REDIRECT with `jmp_pc`=32'h500 and `flush`=1, even though `stall_req` stays 1.
- Macro on, `irq`=1 and `br_taken` together at `pc`=32'hC0 -> `jmp_pc`=32'h10, `epc`=32'hC0, `irq_ack` 1-cycle pulse. Macro off, same stimulus -> `jmp_pc`=branch target, `irq_ack`=0.
- `reset` asserted during SQUASH -> `flush`, `pc_selector`, `jmp_pc` at 0 immediately; after release, state is RUN with no residual flush.
